// File: rtl/rxlogic.sv
// UART 8N1 receiver: synchronises rx into sys_clk, frames start/data/stop bits
// and emits one-cycle data_valid / framing_error strobes.
module rxlogic #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             rx_s1, rx_s;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [7:0]       rx_data_nxt;
  logic             data_valid_nxt, framing_error_nxt;

  // Two-flop synchroniser; idle-high so reset looks like an idle line
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s  <= rx_s1;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      rx_data       <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      bit_cnt       <= bit_cnt_nxt;
      bit_idx       <= bit_idx_nxt;
      shreg         <= shreg_nxt;
      rx_data       <= rx_data_nxt;
      data_valid    <= data_valid_nxt;
      framing_error <= framing_error_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    bit_cnt_nxt       = bit_cnt;
    bit_idx_nxt       = bit_idx;
    shreg_nxt         = shreg;
    rx_data_nxt       = rx_data;
    data_valid_nxt    = 1'b0;
    framing_error_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt   = START;
          bit_cnt_nxt = '0;
        end
      end
      START: begin
        // Mid-start-bit recheck rejects glitches shorter than half a bit
        if (bit_cnt == HALF_CNT) begin
          bit_cnt_nxt = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (bit_cnt == LAST_CNT) begin
          bit_cnt_nxt = '0;
          shreg_nxt   = {rx_s, shreg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_ONE;
        end
      end
      STOP: begin
        if (bit_cnt == LAST_CNT) begin
          bit_cnt_nxt = '0;
          if (rx_s) begin
            rx_data_nxt    = shreg;
            data_valid_nxt = 1'b1;
            state_nxt      = IDLE;
          end else begin
            framing_error_nxt = 1'b1;
            state_nxt         = WAIT_HIGH;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        // Line in break: wait for it to return high before re-arming
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rxlogic.sv
// Directed bench for rxlogic at 16 clocks per bit; a negedge monitor records
// every data_valid / framing_error pulse for the sequence checks.
module tb_rxlogic;

  localparam int BIT = 16;

  logic       sys_clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int dv_cnt   = 0;
  int fe_cnt   = 0;
  logic [7:0] byte_q[$];
  int         cyc_q[$];

  rxlogic #(.CLKS_PER_BIT(BIT)) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .rx            (rx),
    .rx_data       (rx_data),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (!rst) begin
      if (data_valid || framing_error)
        check("dv_fe_exclusive", {31'd0, data_valid & framing_error}, 32'd0);
      if (data_valid) begin
        dv_cnt++;
        byte_q.push_back(rx_data);
        cyc_q.push_back(cyc);
      end
      if (framing_error) fe_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BIT);
    end
    rx = stop_bit;
    tick(BIT);
  endtask

  int fall_cyc;
  int base_dv;
  int base_fe;

  initial begin
    rst = 1'b0;
    rx  = 1'b1;

    // 1: asynchronous reset mid-cycle
    #7 rst = 1'b1;
    #1;
    check("rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("rst_dv", {31'd0, data_valid}, 32'd0);
    check("rst_fe", {31'd0, framing_error}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    tick(3);
    rst = 1'b0;
    tick(5);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // 2: single byte 0x55 with latency
    base_dv  = dv_cnt;
    fall_cyc = cyc;
    send_frame(8'h55, 1'b1);
    rx = 1'b1;
    tick(10);
    check("t2_dv_count", dv_cnt - base_dv, 32'd1);
    if (dv_cnt > base_dv) begin
      check("t2_byte", {24'd0, byte_q[base_dv]}, 32'h55);
      check("t2_latency", cyc_q[base_dv] - fall_cyc, 32'd155);
    end
    check("t2_fe_count", fe_cnt, 32'd0);
    check("t2_rx_data_hold", {24'd0, rx_data}, 32'h55);

    // 3: back-to-back frames
    base_dv = dv_cnt;
    send_frame(8'hF0, 1'b1);
    send_frame(8'h0F, 1'b1);
    send_frame(8'hAA, 1'b1);
    send_frame(8'h55, 1'b1);
    rx = 1'b1;
    tick(10);
    check("t3_dv_count", dv_cnt - base_dv, 32'd4);
    if (dv_cnt >= base_dv + 4) begin
      check("t3_byte0", {24'd0, byte_q[base_dv]},     32'hF0);
      check("t3_byte1", {24'd0, byte_q[base_dv + 1]}, 32'h0F);
      check("t3_byte2", {24'd0, byte_q[base_dv + 2]}, 32'hAA);
      check("t3_byte3", {24'd0, byte_q[base_dv + 3]}, 32'h55);
      for (int i = 1; i < 4; i++)
        check("t3_spacing", cyc_q[base_dv + i] - cyc_q[base_dv + i - 1], 32'd160);
    end
    check("t3_fe_count", fe_cnt, 32'd0);

    // 4: glitch rejection
    base_dv = dv_cnt;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2);
    check("t4_busy_high", {31'd0, busy}, 32'd1);
    tick(20);
    check("t4_busy_low", {31'd0, busy}, 32'd0);
    check("t4_dv_count", dv_cnt - base_dv, 32'd0);
    check("t4_fe_count", fe_cnt, 32'd0);
    check("t4_rx_data", {24'd0, rx_data}, 32'h55);

    // 5: framing error followed by break, then recovery
    base_dv = dv_cnt;
    base_fe = fe_cnt;
    send_frame(8'hA5, 1'b0);
    tick(5 * BIT);
    check("t5_fe_count", fe_cnt - base_fe, 32'd1);
    check("t5_dv_count", dv_cnt - base_dv, 32'd0);
    check("t5_rx_data_kept", {24'd0, rx_data}, 32'h55);
    check("t5_busy_in_break", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    tick(5);
    check("t5_busy_released", {31'd0, busy}, 32'd0);
    send_frame(8'h3C, 1'b1);
    rx = 1'b1;
    tick(10);
    check("t5_dv_after", dv_cnt - base_dv, 32'd1);
    if (dv_cnt > base_dv)
      check("t5_byte", {24'd0, byte_q[base_dv]}, 32'h3C);
    check("t5_fe_total", fe_cnt - base_fe, 32'd1);

    // 6: reset during data bit 4 of 0xFF
    base_dv = dv_cnt;
    base_fe = fe_cnt;
    rx = 1'b0;
    tick(BIT);
    rx = 1'b1;
    tick(4 * BIT + BIT / 2);
    check("t6_busy_before", {31'd0, busy}, 32'd1);
    #4 rst = 1'b1;
    #1;
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("t6_rst_dv", {31'd0, data_valid}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(5 * BIT);
    check("t6_no_dv", dv_cnt - base_dv, 32'd0);
    check("t6_no_fe", fe_cnt - base_fe, 32'd0);
    send_frame(8'h81, 1'b1);
    rx = 1'b1;
    tick(10);
    check("t6_dv_count", dv_cnt - base_dv, 32'd1);
    if (dv_cnt > base_dv)
      check("t6_byte", {24'd0, byte_q[base_dv]}, 32'h81);
    check("t6_rx_data", {24'd0, rx_data}, 32'h81);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rxlogic.md
Name: rxlogic

Overview:
- UART receive datapath; the counterpart of the transmit path (txfifo -> txlogic -> tx).
- Samples the asynchronous serial line rx in the sys_clk domain and frames 8N1 characters: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Delivers each good byte with a one-cycle data_valid strobe, for an RX FIFO or the processor interface.
- Flags framing errors and holds off re-arming while the line stays in break.

Parameters:
CLKS_PER_BIT, 434, sys_clk cycles per serial bit (50 MHz / 115200); must be even and >= 8
HALF_BIT, CLKS_PER_BIT/2, derived; offset from start-bit detection to the first sample point

Ports:
sys_clk  input  1  system clock (50 MHz)
rst  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to sys_clk
rx_data  output  8  last correctly framed byte
data_valid  output  1  one-cycle pulse: rx_data updated this cycle
framing_error  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- One clock, sys_clk. Reset is asynchronous and active-high.
- Reset values:
  - rx_data = 8'h00; data_valid, framing_error and busy = 0.
  - Both synchroniser flops = 1. State = IDLE. Counters and shift register = 0.
- Input sync: rx goes through two flops (rx_s1 -> rx_s). All decisions use rx_s only, so there are 2 cycles of input latency.
- bit_cnt: 0..CLKS_PER_BIT-1. bit_idx: 3 bits. shreg: 8 bits, shifts right with the new bit inserted at bit 7.
- States:
  - IDLE: if rx_s==0, go to START with bit_cnt=0. Call this edge T0.
  - START: count up. When bit_cnt==HALF_BIT-1, i.e. the sample at T0+HALF_BIT:
    - rx_s==0: go to DATA with bit_cnt=0, bit_idx=0.
    - rx_s==1: glitch; go to IDLE with no pulse.
  - DATA: when bit_cnt==CLKS_PER_BIT-1, shift rx_s into shreg and reset bit_cnt. After the bit_idx==7 sample, go to STOP. Data samples fall at T0+HALF_BIT+k*CLKS_PER_BIT, k=1..8.
  - STOP: when bit_cnt==CLKS_PER_BIT-1 (sample at T0+HALF_BIT+9*CLKS_PER_BIT):
    - rx_s==1: rx_data<=shreg, data_valid<=1, go to IDLE.
    - rx_s==0: framing_error<=1, rx_data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. A held-low line (break) produces exactly one framing_error and does not retrigger.
- Pulse timing: data_valid and framing_error are registered; they are high for exactly the one cycle after the stop-sample edge, never both together.
- rx_data holds its value until the next good frame.
- busy=1 in START, DATA, STOP and WAIT_HIGH.
- Back-to-back frames: the stop sample returns to IDLE at mid-stop-bit, so a start edge arriving half a bit later is detected. There is no inter-frame gap requirement.
- Data is passed through unchecked; no parity.
- Reset mid-frame: immediate return to IDLE with all outputs cleared. No pulse is emitted for the partial frame.
- The downstream consumer must capture rx_data on data_valid. There is no backpressure; overrun handling belongs to the FIFO.

Test Plan (CLKS_PER_BIT=16, sys_clk period 20 ns, bit time 320 ns):
1. Reset check: assert rst asynchronously mid-cycle with rx=1 -> all outputs 0 immediately; busy stays 0 after release.
2. Single byte: drive 8'h55 as 8N1 -> exactly one data_valid with rx_data=8'h55, 2+8+9*16+1 cycles after the rx falling edge; framing_error never asserted.
3. Back-to-back frames: send 8'hF0, 8'h0F, 8'hAA, 8'h55 with no idle gap -> four data_valid pulses in order with those values, one per 160 cycles.
4. Glitch rejection: rx low for 3 cycles then high -> busy pulses, returns to IDLE, no data_valid, no framing_error, rx_data unchanged.
5. Framing error and break: send 8'hA5 with stop bit 0 and hold rx low for 5 bit times -> one framing_error; rx_data keeps its previous value; busy stays 1 until rx rises; a following 8'h3C frame is received correctly.
6. Reset mid-frame: assert rst during data bit 4 of 8'hFF -> no pulse; the next full frame 8'h81 is received correctly.
